l2_output_encoder: RTL and testbench

//  Outbound side of the L2 controller. Buffers messages produced by the L2 core FSM into one FIFO per

---
 rtl/l2_output_encoder_pkg.sv | 37 +++
 rtl/l2_output_encoder_fifo.sv | 55 +++++
 rtl/l2_output_encoder.sv | 73 +++++++
 tb/tb_l2_output_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2_output_encoder_pkg.sv
// Shared message types and defaults for the L2 outbound encoder.
package l2_output_encoder_pkg;

  localparam int unsigned L2_OUT_FIFO_DEPTH = 4;

  localparam int unsigned COH_MSG_BITS   = 3;
  localparam int unsigned HPROT_BITS     = 1;
  localparam int unsigned LINE_ADDR_BITS = 28;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned CACHE_ID_BITS  = 4;

  typedef logic [COH_MSG_BITS-1:0]             coh_msg_t;
  typedef logic [HPROT_BITS-1:0]               hprot_t;
  typedef logic [LINE_ADDR_BITS-1:0]           line_addr_t;
  typedef logic [WORDS_PER_LINE*WORD_BITS-1:0] line_t;
  typedef logic [WORDS_PER_LINE-1:0]           word_mask_t;
  typedef logic [CACHE_ID_BITS-1:0]            cache_id_t;

  typedef struct packed {
    coh_msg_t   coh_msg;
    hprot_t     hprot;
    line_addr_t addr;
    line_t      line;
    word_mask_t word_mask;
  } l2_req_out_t;

  typedef struct packed {
    coh_msg_t   coh_msg;
    cache_id_t  req_id;
    logic       to_req;
    line_addr_t addr;
    line_t      line;
    word_mask_t word_mask;
  } l2_rsp_out_t;

endpackage

// File: rtl/l2_output_encoder_fifo.sv
// Single-channel outbound FIFO: registered count, fall-through head, sticky overflow.
module l2_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the registered count; a same-cycle pop never frees room.
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign valid   = (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && full) ovf <= 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_output_encoder.sv
// L2 outbound encoder: four independent channel FIFOs plus stall/idle/overflow reduction.
module l2_output_encoder
  import l2_output_encoder_pkg::*;
#(
  parameter int unsigned DEPTH        = L2_OUT_FIFO_DEPTH,
  parameter int unsigned STALL_MARGIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_out_push,
  input  l2_req_out_t req_out_data,
  output logic        req_out_valid_int,
  input  logic        req_out_ready_int,
  output l2_req_out_t req_out_data_int,
  input  logic        rsp_out_push,
  input  l2_rsp_out_t rsp_out_data,
  output logic        rsp_out_valid_int,
  input  logic        rsp_out_ready_int,
  output l2_rsp_out_t rsp_out_data_int,
  input  logic        rd_rsp_push,
  input  line_t       rd_rsp_data,
  output logic        rd_rsp_valid_int,
  input  logic        rd_rsp_ready_int,
  output line_t       rd_rsp_data_int,
  input  logic        inval_push,
  input  line_addr_t  inval_data,
  output logic        inval_valid_int,
  input  logic        inval_ready_int,
  output line_addr_t  inval_data_int,
  output logic        out_stall,
  output logic        idle,
  output logic [3:0]  ovf_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - STALL_MARGIN);

  logic [CW-1:0] cnt [4];
  logic [3:0]    ovf;

  l2_out_fifo #(.WIDTH($bits(l2_req_out_t)), .DEPTH(DEPTH)) u_req_out (
    .clk(clk), .rst(rst), .push(req_out_push), .din(req_out_data),
    .pop(req_out_ready_int), .dout(req_out_data_int), .valid(req_out_valid_int),
    .count(cnt[0]), .ovf(ovf[0]));

  l2_out_fifo #(.WIDTH($bits(l2_rsp_out_t)), .DEPTH(DEPTH)) u_rsp_out (
    .clk(clk), .rst(rst), .push(rsp_out_push), .din(rsp_out_data),
    .pop(rsp_out_ready_int), .dout(rsp_out_data_int), .valid(rsp_out_valid_int),
    .count(cnt[1]), .ovf(ovf[1]));

  l2_out_fifo #(.WIDTH($bits(line_t)), .DEPTH(DEPTH)) u_rd_rsp (
    .clk(clk), .rst(rst), .push(rd_rsp_push), .din(rd_rsp_data),
    .pop(rd_rsp_ready_int), .dout(rd_rsp_data_int), .valid(rd_rsp_valid_int),
    .count(cnt[2]), .ovf(ovf[2]));

  l2_out_fifo #(.WIDTH($bits(line_addr_t)), .DEPTH(DEPTH)) u_inval (
    .clk(clk), .rst(rst), .push(inval_push), .din(inval_data),
    .pop(inval_ready_int), .dout(inval_data_int), .valid(inval_valid_int),
    .count(cnt[3]), .ovf(ovf[3]));

  // free <= STALL_MARGIN rewritten as count >= DEPTH - STALL_MARGIN to stay unsigned.
  always_comb begin
    out_stall = 1'b0;
    idle      = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (cnt[i] >= STALL_AT) out_stall = 1'b1;
      if (cnt[i] != '0)       idle      = 1'b0;
    end
  end

  assign ovf_err = ovf;

endmodule

// File: tb/tb_l2_output_encoder.sv
// Directed-vector bench for l2_output_encoder with default DEPTH=4, STALL_MARGIN=1.
module tb_l2_output_encoder;
  import l2_output_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_out_push = 1'b0, req_out_ready_int = 1'b0;
  l2_req_out_t req_out_data = '0, req_out_data_int;
  logic        req_out_valid_int;
  logic        rsp_out_push = 1'b0, rsp_out_ready_int = 1'b0;
  l2_rsp_out_t rsp_out_data = '0, rsp_out_data_int;
  logic        rsp_out_valid_int;
  logic        rd_rsp_push = 1'b0, rd_rsp_ready_int = 1'b0;
  line_t       rd_rsp_data = '0, rd_rsp_data_int;
  logic        rd_rsp_valid_int;
  logic        inval_push = 1'b0, inval_ready_int = 1'b0;
  line_addr_t  inval_data = '0, inval_data_int;
  logic        inval_valid_int;
  logic        out_stall, idle;
  logic [3:0]  ovf_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_output_encoder #(.DEPTH(4), .STALL_MARGIN(1)) dut (
    .clk(clk), .rst(rst),
    .req_out_push(req_out_push), .req_out_data(req_out_data),
    .req_out_valid_int(req_out_valid_int), .req_out_ready_int(req_out_ready_int),
    .req_out_data_int(req_out_data_int),
    .rsp_out_push(rsp_out_push), .rsp_out_data(rsp_out_data),
    .rsp_out_valid_int(rsp_out_valid_int), .rsp_out_ready_int(rsp_out_ready_int),
    .rsp_out_data_int(rsp_out_data_int),
    .rd_rsp_push(rd_rsp_push), .rd_rsp_data(rd_rsp_data),
    .rd_rsp_valid_int(rd_rsp_valid_int), .rd_rsp_ready_int(rd_rsp_ready_int),
    .rd_rsp_data_int(rd_rsp_data_int),
    .inval_push(inval_push), .inval_data(inval_data),
    .inval_valid_int(inval_valid_int), .inval_ready_int(inval_ready_int),
    .inval_data_int(inval_data_int),
    .out_stall(out_stall), .idle(idle), .ovf_err(ovf_err));

  function automatic l2_req_out_t mk_req(input line_addr_t a);
    mk_req = '0;
    mk_req.coh_msg   = 3'd2;
    mk_req.addr      = a;
    mk_req.line      = {100'd0, a};
    mk_req.word_mask = 4'hF;
  endfunction

  function automatic l2_rsp_out_t mk_rsp(input line_addr_t a);
    mk_rsp = '0;
    mk_rsp.coh_msg = 3'd5;
    mk_rsp.req_id  = a[3:0];
    mk_rsp.to_req  = 1'b1;
    mk_rsp.addr    = a;
    mk_rsp.line    = {a, 100'd0};
  endfunction

  function automatic line_t mk_line(input int i);
    mk_line = {4{32'hA500_0000 | 32'(i)}};
  endfunction

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_out_valid_int !== 1'b0 || rsp_out_valid_int !== 1'b0 ||
                 rd_rsp_valid_int !== 1'b0 || inval_valid_int !== 1'b0) begin
      bad++; $display("FAIL reset_valid got %b%b%b%b want 0000", req_out_valid_int,
                      rsp_out_valid_int, rd_rsp_valid_int, inval_valid_int);
    end
    total++; if (req_out_data_int !== '0 || inval_data_int !== '0) begin
      bad++; $display("FAIL reset_data got %h/%h want 0", req_out_data_int.addr, inval_data_int);
    end
    step(); rst = 1'b1; step(); step();
    total++; if (idle !== 1'b1 || out_stall !== 1'b0 || ovf_err !== 4'b0000) begin
      bad++; $display("FAIL reset_idle got idle=%b stall=%b ovf=%b want 1 0 0000", idle, out_stall, ovf_err);
    end
  endtask

  task automatic test_req_stall();
    req_out_push = 1'b1;
    req_out_data = mk_req(28'h100); step();
    total++; if (req_out_valid_int !== 1'b1 || req_out_data_int !== mk_req(28'h100)) begin
      bad++; $display("FAIL req_first got v=%b a=%h want 1 100", req_out_valid_int, req_out_data_int.addr);
    end
    req_out_data = mk_req(28'h101); step();
    total++; if (out_stall !== 1'b0 || req_out_data_int !== mk_req(28'h100)) begin
      bad++; $display("FAIL req_two got stall=%b a=%h want 0 100", out_stall, req_out_data_int.addr);
    end
    req_out_data = mk_req(28'h102); step();
    req_out_push = 1'b0;
    total++; if (out_stall !== 1'b1 || req_out_data_int !== mk_req(28'h100)) begin
      bad++; $display("FAIL req_three got stall=%b a=%h want 1 100", out_stall, req_out_data_int.addr);
    end
    step();
    total++; if (req_out_valid_int !== 1'b1 || req_out_data_int !== mk_req(28'h100) || idle !== 1'b0) begin
      bad++; $display("FAIL req_hold got v=%b a=%h idle=%b want 1 100 0", req_out_valid_int,
                      req_out_data_int.addr, idle);
    end
    req_out_ready_int = 1'b1; step();
    total++; if (out_stall !== 1'b0 || req_out_data_int !== mk_req(28'h101)) begin
      bad++; $display("FAIL req_pop1 got stall=%b a=%h want 0 101", out_stall, req_out_data_int.addr);
    end
    step();
    total++; if (req_out_valid_int !== 1'b1 || req_out_data_int !== mk_req(28'h102)) begin
      bad++; $display("FAIL req_pop2 got v=%b a=%h want 1 102", req_out_valid_int, req_out_data_int.addr);
    end
    step();
    req_out_ready_int = 1'b0;
    total++; if (req_out_valid_int !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL req_drained got v=%b idle=%b want 0 1", req_out_valid_int, idle);
    end
  endtask

  task automatic test_overflow();
    rsp_out_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rsp_out_data = mk_rsp(28'h010 + 28'(i)); step();
    end
    rsp_out_data = mk_rsp(28'h1FF); step();
    rsp_out_push = 1'b0;
    total++; if (ovf_err !== 4'b0010 || out_stall !== 1'b1) begin
      bad++; $display("FAIL ovf_flag got ovf=%b stall=%b want 0010 1", ovf_err, out_stall);
    end
    rsp_out_ready_int = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_out_valid_int !== 1'b1 || rsp_out_data_int !== mk_rsp(28'h010 + 28'(i))) begin
        bad++; $display("FAIL ovf_drain%0d got v=%b a=%h want 1 %h", i, rsp_out_valid_int,
                        rsp_out_data_int.addr, 28'h010 + 28'(i));
      end
      step();
    end
    rsp_out_ready_int = 1'b0;
    total++; if (rsp_out_valid_int !== 1'b0 || idle !== 1'b1 || ovf_err !== 4'b0010) begin
      bad++; $display("FAIL ovf_after got v=%b idle=%b ovf=%b want 0 1 0010", rsp_out_valid_int, idle, ovf_err);
    end
  endtask

  task automatic test_stream();
    rd_rsp_ready_int = 1'b1;
    rd_rsp_push = 1'b1;
    rd_rsp_data = mk_line(0); step();
    for (int i = 1; i <= 16; i++) begin
      total++; if (rd_rsp_valid_int !== 1'b1 || rd_rsp_data_int !== mk_line(i-1) || idle !== 1'b0 ||
                   out_stall !== 1'b0) begin
        bad++; $display("FAIL stream%0d got v=%b d=%h idle=%b stall=%b want 1 %h 0 0", i, rd_rsp_valid_int,
                        rd_rsp_data_int[31:0], idle, out_stall, mk_line(i-1) & 128'hFFFF_FFFF);
      end
      rd_rsp_data = mk_line(i); step();
    end
    rd_rsp_push = 1'b0;
    total++; if (rd_rsp_data_int !== mk_line(16) || ovf_err[2] !== 1'b0) begin
      bad++; $display("FAIL stream_last got d=%h ovf=%b want %h 0", rd_rsp_data_int[31:0], ovf_err[2],
                      32'hA500_0010);
    end
    step();
    rd_rsp_ready_int = 1'b0;
    total++; if (rd_rsp_valid_int !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL stream_end got v=%b idle=%b want 0 1", rd_rsp_valid_int, idle);
    end
  endtask

  task automatic test_all_channels();
    req_out_ready_int = 1'b1; rsp_out_ready_int = 1'b1; rd_rsp_ready_int = 1'b1; inval_ready_int = 1'b1;
    req_out_push = 1'b1; rsp_out_push = 1'b1; rd_rsp_push = 1'b1; inval_push = 1'b1;
    req_out_data = mk_req(28'hAAA); rsp_out_data = mk_rsp(28'hBBB);
    rd_rsp_data = mk_line(77); inval_data = 28'hCCC;
    step();
    req_out_push = 1'b0; rsp_out_push = 1'b0; rd_rsp_push = 1'b0; inval_push = 1'b0;
    total++; if (req_out_data_int !== mk_req(28'hAAA) || rsp_out_data_int !== mk_rsp(28'hBBB) ||
                 rd_rsp_data_int !== mk_line(77) || inval_data_int !== 28'hCCC) begin
      bad++; $display("FAIL all_data got %h %h %h %h want aaa bbb a500004d ccc", req_out_data_int.addr,
                      rsp_out_data_int.addr, rd_rsp_data_int[31:0], inval_data_int);
    end
    total++; if ({req_out_valid_int, rsp_out_valid_int, rd_rsp_valid_int, inval_valid_int} !== 4'b1111) begin
      bad++; $display("FAIL all_valid got %b%b%b%b want 1111", req_out_valid_int, rsp_out_valid_int,
                      rd_rsp_valid_int, inval_valid_int);
    end
    step();
    req_out_ready_int = 1'b0; rsp_out_ready_int = 1'b0; rd_rsp_ready_int = 1'b0; inval_ready_int = 1'b0;
    total++; if (idle !== 1'b1) begin
      bad++; $display("FAIL all_idle got %b want 1", idle);
    end
  endtask

  task automatic test_reset_mid();
    inval_push = 1'b1;
    inval_data = 28'h0DEAD01; step();
    inval_data = 28'h0DEAD02; step();
    inval_push = 1'b0;
    total++; if (inval_valid_int !== 1'b1 || inval_data_int !== 28'h0DEAD01) begin
      bad++; $display("FAIL mid_pre got v=%b d=%h want 1 0dead01", inval_valid_int, inval_data_int);
    end
    rst = 1'b0; #1;
    total++; if (inval_valid_int !== 1'b0 || idle !== 1'b1 || ovf_err !== 4'b0000) begin
      bad++; $display("FAIL mid_async got v=%b idle=%b ovf=%b want 0 1 0000", inval_valid_int, idle, ovf_err);
    end
    step(); #2; rst = 1'b1; step();
    total++; if (inval_valid_int !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL mid_release got v=%b idle=%b want 0 1", inval_valid_int, idle);
    end
    inval_push = 1'b1; inval_data = 28'h0BEEF00; step();
    inval_push = 1'b0;
    total++; if (inval_valid_int !== 1'b1 || inval_data_int !== 28'h0BEEF00) begin
      bad++; $display("FAIL mid_fresh got v=%b d=%h want 1 0beef00", inval_valid_int, inval_data_int);
    end
    inval_ready_int = 1'b1; step();
    inval_ready_int = 1'b0;
    total++; if (inval_valid_int !== 1'b0 || idle !== 1'b1) begin
      bad++; $display("FAIL mid_only_one got v=%b idle=%b want 0 1", inval_valid_int, idle);
    end
  endtask

  initial begin
    test_reset();
    test_req_stall();
    test_overflow();
    test_stream();
    test_all_channels();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
